// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the writeback stage: result request layout
// and the source identifiers used by the round-robin pointer.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       dat;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/writeback_arbiter_slot.sv
// One-entry holding slot between a result producer and the writeback arbiter.
// Ready depends only on registered occupancy, the grant and flush, never on valid.
module wb_slot
  import wb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_flush,
  input  logic    i_valid,
  output logic    o_ready,
  input  wb_req_t i_req,
  input  logic    i_grant,
  output logic    o_occupied,
  output wb_req_t o_req
);

  logic    r_occ;
  wb_req_t r_req;
  logic    w_capture;

  // A slot being drained this cycle can be refilled on the same edge.
  assign o_ready   = ~i_flush & (~r_occ | i_grant);
  assign w_capture = i_valid & o_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= 1'b0;
      // NOTE: the payload is reset too; it is a single register, not a memory
      // array, so the cost is trivial and it keeps write_addr/write_dat defined.
      r_req <= '0;
    end else if (i_flush) begin
      r_occ <= 1'b0;
    end else if (w_capture) begin
      r_occ <= 1'b1;
      r_req <= i_req;
    end else if (i_grant) begin
      r_occ <= 1'b0;
    end
  end

  assign o_occupied = r_occ;
  assign o_req      = r_req;

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage: two result slots (ALU, LSU) drained round-robin into a
// registered register-file write port, plus a pending-destination mask for decode.
module writeback_arbiter #(
  parameter int XLEN       = wb_pkg::XLEN,
  parameter int REG_ADDR_W = wb_pkg::REG_ADDR_W,
  parameter int NUM_REGS   = wb_pkg::NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_dat,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_dat,
  output logic                  write_en,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [XLEN-1:0]       write_dat,
  output logic [NUM_REGS-1:0]   pending_mask
);

  wb_pkg::wb_req_t w_alu_in, w_lsu_in;
  wb_pkg::wb_req_t w_alu_req, w_lsu_req, w_win_req;
  logic            w_alu_occ, w_lsu_occ;
  logic            w_alu_grant, w_lsu_grant, w_any_grant;
  logic [NUM_REGS-1:0] w_pending;

  wb_pkg::wb_src_e       r_last_grant;
  logic                  r_write_en;
  logic [REG_ADDR_W-1:0] r_write_addr;
  logic [XLEN-1:0]       r_write_dat;

  assign w_alu_in = '{rd: alu_rd, dat: alu_dat};
  assign w_lsu_in = '{rd: lsu_rd, dat: lsu_dat};

  wb_slot u_alu_slot (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (flush),
    .i_valid    (alu_valid),
    .o_ready    (alu_ready),
    .i_req      (w_alu_in),
    .i_grant    (w_alu_grant),
    .o_occupied (w_alu_occ),
    .o_req      (w_alu_req)
  );

  wb_slot u_lsu_slot (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (flush),
    .i_valid    (lsu_valid),
    .o_ready    (lsu_ready),
    .i_req      (w_lsu_in),
    .i_grant    (w_lsu_grant),
    .o_occupied (w_lsu_occ),
    .o_req      (w_lsu_req)
  );

  // On a tie the source that did not win last time goes first.
  assign w_alu_grant = w_alu_occ & (~w_lsu_occ | (r_last_grant == wb_pkg::SRC_LSU));
  assign w_lsu_grant = w_lsu_occ & ~w_alu_grant;
  assign w_any_grant = w_alu_grant | w_lsu_grant;
  assign w_win_req   = w_alu_grant ? w_alu_req : w_lsu_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= wb_pkg::SRC_LSU;
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_dat  <= '0;
    end else begin
      r_write_en <= 1'b0;
      if (!flush && w_any_grant) begin
        r_write_en   <= (w_win_req.rd != '0);
        r_write_addr <= w_win_req.rd;
        r_write_dat  <= w_win_req.dat;
        r_last_grant <= w_alu_grant ? wb_pkg::SRC_ALU : wb_pkg::SRC_LSU;
      end
    end
  end

  // NOTE: every bit gets a default before the conditional sets, so no latch
  // is inferred for the mask.
  always_comb begin
    w_pending = '0;
    if (w_alu_occ) w_pending[w_alu_req.rd] = 1'b1;
    if (w_lsu_occ) w_pending[w_lsu_req.rd] = 1'b1;
    w_pending[0] = 1'b0;
  end

  assign pending_mask = w_pending;
  assign write_en     = r_write_en;
  assign write_addr   = r_write_addr;
  assign write_dat    = r_write_dat;

  // Upstream promises at most one in-flight result per architectural register.
  a_unique_rd: assert property (@(posedge clk) disable iff (rst)
    !(w_alu_occ && w_lsu_occ && (w_alu_req.rd == w_lsu_req.rd) && (w_alu_req.rd != '0)));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: a transaction-level model predicts
// each register write and its cycle; a negedge monitor pops and compares.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_rd = '0, lsu_rd = '0;
  logic [31:0] alu_dat = '0, lsu_dat = '0;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_dat;
  logic [31:0] pending_mask;

  writeback_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_dat      (alu_dat),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_dat      (lsu_dat),
    .write_en     (write_en),
    .write_addr   (write_addr),
    .write_dat    (write_dat),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        full;
    logic [4:0]  rd;
    logic [31:0] dat;
  } mslot_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] dat;
    int          due;
  } exp_t;

  mslot_t m_slot [2];   // index 0 = ALU, 1 = LSU
  int     m_last = 1;   // source served most recently
  exp_t   exp_q [$];
  int     cyc = 0;
  int     n_cmp = 0, n_err = 0, n_writes = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Which source is served this cycle: alternate on a tie, else the only one waiting.
  function automatic int pick();
    if (m_slot[0].full && m_slot[1].full) return 1 - m_last;
    if (m_slot[0].full) return 0;
    if (m_slot[1].full) return 1;
    return -1;
  endfunction

  function automatic logic model_ready(int s);
    return !flush && (!m_slot[s].full || pick() == s);
  endfunction

  task automatic model_edge();
    int   win;
    logic rdy0, rdy1;
    cyc++;
    win  = pick();
    rdy0 = model_ready(0);
    rdy1 = model_ready(1);
    if (flush) begin
      m_slot[0].full = 1'b0;
      m_slot[1].full = 1'b0;
    end else begin
      if (win >= 0) begin
        if (m_slot[win].rd != 5'd0)
          exp_q.push_back('{rd: m_slot[win].rd, dat: m_slot[win].dat, due: cyc});
        m_last = win;
        m_slot[win].full = 1'b0;
      end
      if (alu_valid && rdy0) m_slot[0] = '{full: 1'b1, rd: alu_rd, dat: alu_dat};
      if (lsu_valid && rdy1) m_slot[1] = '{full: 1'b1, rd: lsu_rd, dat: lsu_dat};
    end
  endtask

  task automatic monitor_sample();
    logic [31:0] em;
    exp_t        e;
    em = '0;
    for (int s = 0; s < 2; s++)
      if (m_slot[s].full && m_slot[s].rd != 5'd0) em[m_slot[s].rd] = 1'b1;
    check("alu_ready", alu_ready, model_ready(0));
    check("lsu_ready", lsu_ready, model_ready(1));
    check("pending_mask", pending_mask, em);
    if (write_en) n_writes++;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check("write_en", write_en, 1);
      check("write_addr", write_addr, e.rd);
      check("write_dat", write_dat, e.dat);
    end else begin
      check("write_en_idle", write_en, 0);
    end
  endtask

  always @(posedge clk) if (!rst) model_edge();
  always @(negedge clk) if (!rst) monitor_sample();

  task automatic drive(logic av, logic [4:0] ar, logic [31:0] ad,
                       logic lv, logic [4:0] lr, logic [31:0] ld, logic fl);
    @(posedge clk); #1;
    alu_valid = av; alu_rd = ar; alu_dat = ad;
    lsu_valid = lv; lsu_rd = lr; lsu_dat = ld;
    flush = fl;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    alu_valid = 1'b0; lsu_valid = 1'b0; flush = 1'b0;
    exp_q.delete();
    m_slot[0].full = 1'b0;
    m_slot[1].full = 1'b0;
    m_last = 1;
    #1;
    check("rst_write_en", write_en, 0);
    check("rst_write_addr", write_addr, 0);
    check("rst_write_dat", write_dat, 0);
    check("rst_pending_mask", pending_mask, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_alu_ready", alu_ready, 1);
    check("rst_lsu_ready", lsu_ready, 1);
  endtask

  initial begin
    int base;
    m_slot[0] = '0;
    m_slot[1] = '0;
    do_reset();

    // Single uncontended ALU result: pending in cycle 1, written in cycle 2.
    drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
    @(negedge clk);
    check("single_pending5", pending_mask[5], 1);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
    @(negedge clk);
    check("single_write_en", write_en, 1);
    check("single_write_addr", write_addr, 5);
    check("single_write_dat", write_dat, 32'hDEADBEEF);
    check("single_pending_clear", pending_mask, 0);
    idle(2);

    // First tie after reset goes to ALU, then strict alternation.
    do_reset();
    drive(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0);
    idle(4);
    for (int i = 0; i < 8; i++)
      drive(1, 5'(1 + i), 32'hA000 + i, 1, 5'(16 + i), 32'hB000 + i, 0);
    idle(4);

    // x0 result drains without a write or a pending bit.
    drive(0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFFFFFF, 0);
    idle(4);

    // Backpressure: both sources valid every cycle gives one write per cycle.
    for (int i = 0; i < 4; i++)
      drive(1, 5'(1 + i), 32'hC000 + i, 1, 5'(16 + i), 32'hD000 + i, 0);
    base = n_writes;
    for (int i = 0; i < 16; i++)
      drive(1, 5'(1 + (i % 15)), 32'hC100 + i, 1, 5'(16 + (i % 16)), 32'hD100 + i, 0);
    check("backpressure_writes", n_writes - base, 16);
    idle(4);

    // Flush with both slots full: nothing written, tie order unchanged after.
    drive(1, 5'd7, 32'h77, 1, 5'd20, 32'h2020, 0);
    drive(1, 5'd8, 32'h88, 1, 5'd21, 32'h2121, 1);
    idle(3);
    drive(1, 5'd9, 32'h99, 1, 5'd22, 32'h2222, 0);
    idle(4);

    // Reset with both slots occupied.
    drive(1, 5'd10, 32'h1010, 1, 5'd23, 32'h2323, 0);
    do_reset();
    idle(2);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 3) != 0,
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 15)),
              $urandom(),
              $urandom_range(0, 2) != 0,
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31)),
              $urandom(),
              $urandom_range(0, 19) == 0);
      end
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
